// File: rtl/uart_board_loader_if.sv
// uart_board_loader_if
//   Byte-in / cell-write-out bundle for the board loader.
//   enable, in_data, in_valid, in_ready : UART receiver byte handshake
//   wr_en, wr_addr, wr_data             : single-cell write into board_state
//   frame_done, err                     : one-cycle status pulses
//   master : byte source / write sink side, slave : the loader.
interface uart_board_loader_if #(
  parameter int logWIDTH  = 3,
  parameter int logHEIGHT = 3
);
  logic                          enable;
  logic [7:0]                    in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          wr_en;
  logic [logWIDTH+logHEIGHT-1:0] wr_addr;
  logic                          wr_data;
  logic                          frame_done;
  logic                          err;

  modport master (
    output enable, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, frame_done, err
  );

  modport slave (
    input  enable, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, frame_done, err
  );
endinterface

// File: rtl/uart_board_loader.sv
// uart_board_loader
//   Parses the ANSI/ASCII board stream ('O' alive, ' ' dead, CR ignored,
//   LF row break with dead padding, ESC [ ; H home) into cell writes.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : uart_board_loader_if.slave (byte handshake in, cell writes
//             and frame_done/err pulses out, all outputs registered except
//             in_ready)
module uart_board_loader #(
  parameter int logWIDTH  = 3,
  parameter int logHEIGHT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_board_loader_if.slave   bus
);

  localparam int AW = logWIDTH + logHEIGHT;

  // col runs 0..WIDTH, so it carries one extra bit
  localparam logic [logWIDTH:0]    COL_END  = {1'b1, {logWIDTH{1'b0}}};
  localparam logic [logWIDTH:0]    COL_LAST = {1'b0, {logWIDTH{1'b1}}};
  localparam logic [logWIDTH:0]    COL_ONE  = {{logWIDTH{1'b0}}, 1'b1};
  localparam logic [logHEIGHT-1:0] ROW_LAST = '1;
  localparam logic [logHEIGHT-1:0] ROW_ONE  = {{(logHEIGHT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {RUN, PAD, ESC1, ESC2, ESC3} state_t;

  state_t               state, state_n;
  logic [logHEIGHT-1:0] row, row_n;
  logic [logWIDTH:0]    col, col_n;
  // Set on the final pad write; PAD then idles one cycle so in_ready stays
  // low for exactly as many cycles as pad writes were issued.
  logic                 pad_done, pad_done_n;

  logic                 wr_en_q, wr_en_n;
  logic [AW-1:0]        wr_addr_q, wr_addr_n;
  logic                 wr_data_q, wr_data_n;
  logic                 frame_done_q, frame_done_n;
  logic                 err_q, err_n;

  logic                 accept;
  logic                 put, put_val, pad_wr, adv;

  assign bus.in_ready   = ~reset & bus.enable & (state != PAD);
  assign accept         = bus.in_valid & bus.in_ready;

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      row          <= '0;
      col          <= '0;
      pad_done     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_n;
      row          <= row_n;
      col          <= col_n;
      pad_done     <= pad_done_n;
      wr_en_q      <= wr_en_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
      frame_done_q <= frame_done_n;
      err_q        <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    pad_done_n   = pad_done;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr_q;
    wr_data_n    = wr_data_q;
    frame_done_n = 1'b0;
    err_n        = 1'b0;
    put          = 1'b0;
    put_val      = 1'b0;
    pad_wr       = 1'b0;
    adv          = 1'b0;

    unique case (state)
      RUN: if (accept) begin
        unique case (bus.in_data)
          8'd79, 8'd32: begin
            if (col != COL_END) begin
              put     = 1'b1;
              put_val = (bus.in_data == 8'd79);
            end else begin
              err_n = 1'b1;
            end
          end
          8'd13: ;
          8'd10: begin
            // First pad cell is written on the LF itself so the pad burst
            // starts the cycle after the LF is accepted.
            if (col != COL_END) begin
              put     = 1'b1;
              pad_wr  = 1'b1;
              state_n = PAD;
            end else begin
              adv = 1'b1;
            end
          end
          8'd27:   state_n = ESC1;
          default: err_n = 1'b1;
        endcase
      end
      PAD: begin
        if (pad_done) begin
          pad_done_n = 1'b0;
          state_n    = RUN;
        end else begin
          put    = 1'b1;
          pad_wr = 1'b1;
        end
      end
      ESC1: if (accept) begin
        if (bus.in_data == 8'd91) state_n = ESC2;
        else begin state_n = RUN; err_n = 1'b1; end
      end
      ESC2: if (accept) begin
        if (bus.in_data == 8'd59) state_n = ESC3;
        else begin state_n = RUN; err_n = 1'b1; end
      end
      ESC3: if (accept) begin
        state_n = RUN;
        if (bus.in_data == 8'd72) begin
          row_n = '0;
          col_n = '0;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    if (put) begin
      wr_en_n   = 1'b1;
      wr_addr_n = {row, col[logWIDTH-1:0]};
      wr_data_n = put_val;
      col_n     = col + COL_ONE;
    end

    if (pad_wr && col == COL_LAST) begin
      adv        = 1'b1;
      pad_done_n = 1'b1;
    end

    if (adv) begin
      col_n = '0;
      if (row == ROW_LAST) begin
        row_n        = '0;
        frame_done_n = 1'b1;
      end else begin
        row_n = row + ROW_ONE;
      end
    end
  end

endmodule

// File: doc/uart_board_loader.md
# uart_board_loader

Receive-side counterpart of the Game-of-Life board display path: parses the ANSI/ASCII board stream (`O` alive, space dead, CR/LF row breaks, `ESC [ ; H` home) arriving from the UART receiver and converts it into single-cell write strobes into `board_state`. It sits between the UART receiver's valid/ready byte interface and the board memory write port. This lets a host terminal upload an arbitrary 8x8 pattern in the same format the board display emits.

## Interface
- `logWIDTH`, 3, log2 of board width (columns)
- `logHEIGHT`, 3, log2 of board height (rows)
- `clk` input 1 — system clock; all logic on rising edge
- `reset` input 1 — synchronous, active-high
- `enable` input 1 — when low, no new bytes accepted
- `in_data` input 8 — received byte
- `in_valid` input 1 — `in_data` valid
- `in_ready` output 1 — loader can accept; byte consumed on cycle with `in_valid & in_ready`
- `wr_en` output 1 — one-cycle cell write strobe
- `wr_addr` output logWIDTH+logHEIGHT — cell index `{row, col}`
- `wr_data` output 1 — cell state (1 alive)
- `frame_done` output 1 — one-cycle pulse: last row completed
- `err` output 1 — one-cycle pulse: byte rejected

## Operation
- Internal position: `row` (logHEIGHT bits), `col` (logWIDTH+1 bits, range 0..WIDTH). Reset: row=0, col=0.
- States: RUN, PAD, ESC1, ESC2, ESC3. Reset state RUN.
- `in_ready` = `enable` and state in {RUN, ESC1, ESC2, ESC3}. Low in PAD and during reset.
- RUN, accepted byte:
  - 79 (`O`) / 32 (space): if col<WIDTH, write cell (row,col) with 1/0, col+1; if col==WIDTH, no write, `err` pulse.
  - 13 (CR): ignored, no error.
  - 10 (LF): if col<WIDTH → PAD; if col==WIDTH → row advance.
  - 27 (ESC) → ESC1.
  - any other byte: dropped, `err` pulse.
- PAD: one dead-cell write per cycle at (row,col), col+1; on writing col WIDTH-1, row advance and return to RUN.
- Row advance: col←0; if row==HEIGHT-1, row←0 and `frame_done` pulse; else row+1.
- ESC1 expects 91 (`[`) → ESC2; ESC2 expects 59 (`;`) → ESC3; ESC3 expects 72 (`H`) → home: row←0, col←0, RUN, no writes, no `frame_done`. Any mismatching byte: dropped, `err` pulse, back to RUN, position unchanged.
- `enable` deassertion does not abort PAD; PAD runs to completion. State and position retained while disabled.
- Widths: col compare is against WIDTH (needs extra bit); row wraps modulo HEIGHT.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `err`=0.
- `wr_en`/`wr_addr`/`wr_data` registered: byte accepted at cycle N → write strobe at N+1.
- LF accepted at N with k=WIDTH-col>0 pad cells: `wr_en` high N+1..N+k, `in_ready` low N+1..N+k, high again N+k+1 (if `enable`). `frame_done` (last row) coincides with the final pad write at N+k.
- LF accepted at N with col==WIDTH: no writes; `frame_done` (last row) at N+1; `in_ready` stays high.
- `err` at N+1 for a byte rejected at N.
- Full throughput: one byte per cycle in RUN/ESC states.
- Reset asserted mid-PAD or mid-ESC: next cycle all outputs at reset values, state RUN, position 0,0; partial writes not resumed.

## Test plan
- Reset, then stream 8 rows of `O O O O ` ... each `OOOOOOOO\r\n`: 64 writes, addresses 0..63 in order, all `wr_data`=1, single `frame_done` coincident with LF-related cycle after row 7 (N+1), no `err`.
- Row 0 = `OO\n`: writes addr 0,1 data 1 then pad addr 2..7 data 0 on consecutive cycles, `in_ready` low exactly 6 cycles; next `O` writes addr 8.
- `OOOOOOOOO` (9 chars) on row 0: 8 writes, 9th byte gives `err` pulse and no write; following `\r\n` advances to row 1 with no pad.
- After 3 cells in row 2, send `ESC [ ; H` then `O`: no writes for escape, no `frame_done`, `O` writes addr 0. Send `ESC [ X`: `err` at cycle after `X`, state RUN, position unchanged.
- `enable`=0 with `in_valid`=1: `in_ready`=0, no writes; drop `enable` during PAD: pad completes all remaining writes.
- Assert `reset` in the middle of a 6-cell PAD: writes stop next cycle, all outputs 0; after release, `O` writes addr 0.
